// File: rtl/power_sequencer.sv
// power_sequencer: five-rail ordered power-up / reverse power-down sequencer.
// Rails are enabled 0 -> 4. Each rail must report power-good before the next
// rail is enabled. The last rail is followed by a settle period and then
// o_allGood. Shutdown sheds rails from the highest enabled one downwards.
// A fault (power-good timeout or dropout) drops every enable at once.
// Optional feature macro: PSEQ_AUTO_RETRY_EN. When it is defined, a fault
// with i_enable still high is retried after RETRY_DELAY cycles, at most
// three times in a row.
module power_sequencer #(
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd1000,
    parameter logic [31:0] STEP_DELAY     = 32'd100,
    parameter logic [31:0] SETTLE_DELAY   = 32'd1000,
    parameter logic [31:0] RETRY_DELAY    = 32'd10000
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_enable,
    input  logic [4:0] i_pg,
    output logic [4:0] o_en,
    output logic       o_allGood,
    output logic       o_fault,
    output logic [2:0] o_faultRail,
    output logic [1:0] o_faultCode,
    output logic [2:0] o_state
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_RAMP     = 3'd1,
        S_GAP      = 3'd2,
        S_SETTLE   = 3'd3,
        S_RUN      = 3'd4,
        S_SHUTDOWN = 3'd5,
        S_FAULT    = 3'd6
    } state_t;

    state_t      r_state;
    logic [2:0]  r_k;
    logic [31:0] r_cnt;
    logic [4:0]  r_good_mask;
    logic [4:0]  r_en;
    logic        r_all_good;
    logic        r_fault;
    logic [2:0]  r_fault_rail;
    logic [1:0]  r_fault_code;
`ifdef PSEQ_AUTO_RETRY_EN
    logic [1:0]  r_attempt;
`else
    logic        w_unused_retry;
    assign w_unused_retry = ^RETRY_DELAY;
`endif

    logic [4:0]  w_drop;
    logic        w_drop_any;
    logic [2:0]  w_drop_rail;
    logic [4:0]  w_en_shed;
    logic [4:0]  w_next_bit;
    logic        w_pg_cur;
    logic        w_monitor;
    logic        w_timeout;
    logic        w_fault_hit;
    logic        w_abort;
    logic [1:0]  w_fault_code;
    logic [2:0]  w_fault_rail;
    logic [31:0] w_cnt_inc;

    // A confirmed rail whose power-good has fallen is a dropout
    genvar gi;
    generate
        for (gi = 0; gi < 5; gi++) begin : g_drop
            assign w_drop[gi] = r_good_mask[gi] & ~i_pg[gi];
        end
    endgenerate

    assign w_drop_any = |w_drop;

    // Report the lowest rail that dropped out
    always_comb begin
        w_drop_rail = 3'd0;
        for (int i = 4; i >= 0; i--) begin
            if (w_drop[i]) begin
                w_drop_rail = 3'(i);
            end
        end
    end

    // Enable vector with its highest active rail removed (one shutdown step)
    always_comb begin
        w_en_shed = r_en;
        for (int i = 0; i < 5; i++) begin
            if (r_en[i]) begin
                w_en_shed    = r_en;
                w_en_shed[i] = 1'b0;
            end
        end
    end

    assign w_next_bit   = 5'd1 << (r_k + 3'd1);
    assign w_pg_cur     = i_pg[r_k];
    assign w_monitor    = (r_state == S_RAMP) || (r_state == S_GAP) ||
                          (r_state == S_SETTLE) || (r_state == S_RUN);
    assign w_timeout    = (r_state == S_RAMP) && !w_pg_cur &&
                          (r_cnt == TIMEOUT_CYCLES - 32'd1);
    assign w_fault_hit  = w_monitor && (w_drop_any || w_timeout);
    assign w_fault_code = w_drop_any ? 2'd2 : 2'd1;
    assign w_fault_rail = w_drop_any ? w_drop_rail : r_k;
    assign w_abort      = w_monitor && !i_enable;
    // Counter saturates rather than wrapping during long holds
    assign w_cnt_inc    = (r_cnt == 32'hFFFF_FFFF) ? r_cnt : r_cnt + 32'd1;

    // Sequencer FSM: fault beats enable drop, which beats normal progress
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= S_IDLE;
            r_k          <= 3'd0;
            r_cnt        <= 32'd0;
            r_good_mask  <= 5'd0;
            r_en         <= 5'd0;
            r_all_good   <= 1'b0;
            r_fault      <= 1'b0;
            r_fault_rail <= 3'd0;
            r_fault_code <= 2'd0;
`ifdef PSEQ_AUTO_RETRY_EN
            r_attempt    <= 2'd0;
`endif
        end else if (w_fault_hit) begin
            r_state      <= S_FAULT;
            r_en         <= 5'd0;
            r_all_good   <= 1'b0;
            r_fault      <= 1'b1;
            r_fault_code <= w_fault_code;
            r_fault_rail <= w_fault_rail;
            r_cnt        <= 32'd0;
        end else if (w_abort) begin
            // First shutdown step happens on the same edge as the request
            r_en       <= w_en_shed;
            r_all_good <= 1'b0;
            r_cnt      <= 32'd0;
            r_state    <= (w_en_shed == 5'd0) ? S_IDLE : S_SHUTDOWN;
        end else begin
            r_cnt <= w_cnt_inc;
            case (r_state)
                S_IDLE: begin
                    r_en        <= 5'd0;
                    r_good_mask <= 5'd0;
                    r_cnt       <= 32'd0;
                    r_k         <= 3'd0;
`ifdef PSEQ_AUTO_RETRY_EN
                    r_attempt   <= 2'd0;
`endif
                    if (i_enable) begin
                        r_state <= S_RAMP;
                        r_en    <= 5'b00001;
                    end
                end
                S_RAMP: begin
                    if (w_pg_cur) begin
                        r_good_mask[r_k] <= 1'b1;
                        r_cnt            <= 32'd0;
                        if (r_k == 3'd4) begin
                            if (SETTLE_DELAY == 32'd0) begin
                                r_state    <= S_RUN;
                                r_all_good <= 1'b1;
`ifdef PSEQ_AUTO_RETRY_EN
                                r_attempt  <= 2'd0;
`endif
                            end else begin
                                r_state <= S_SETTLE;
                            end
                        end else if (STEP_DELAY == 32'd0) begin
                            r_k  <= r_k + 3'd1;
                            r_en <= r_en | w_next_bit;
                        end else begin
                            r_state <= S_GAP;
                        end
                    end
                end
                S_GAP: begin
                    if (r_cnt == STEP_DELAY - 32'd1) begin
                        r_k     <= r_k + 3'd1;
                        r_en    <= r_en | w_next_bit;
                        r_cnt   <= 32'd0;
                        r_state <= S_RAMP;
                    end
                end
                S_SETTLE: begin
                    if (r_cnt == SETTLE_DELAY - 32'd1) begin
                        r_state    <= S_RUN;
                        r_all_good <= 1'b1;
                        r_cnt      <= 32'd0;
`ifdef PSEQ_AUTO_RETRY_EN
                        r_attempt  <= 2'd0;
`endif
                    end
                end
                S_RUN: begin
                    r_cnt <= 32'd0;
                end
                S_SHUTDOWN: begin
                    // Power-good and i_enable are deliberately ignored here
                    if (r_cnt == STEP_DELAY) begin
                        r_en  <= w_en_shed;
                        r_cnt <= 32'd0;
                        if (w_en_shed == 5'd0) begin
                            r_state <= S_IDLE;
                        end
                    end
                end
                S_FAULT: begin
                    if (!i_enable) begin
                        r_state      <= S_IDLE;
                        r_fault      <= 1'b0;
                        r_fault_code <= 2'd0;
                        r_fault_rail <= 3'd0;
                        r_cnt        <= 32'd0;
                    end
`ifdef PSEQ_AUTO_RETRY_EN
                    else if ((r_attempt != 2'd3) &&
                             ((RETRY_DELAY == 32'd0) || (r_cnt == RETRY_DELAY - 32'd1))) begin
                        r_state      <= S_RAMP;
                        r_k          <= 3'd0;
                        r_en         <= 5'b00001;
                        r_good_mask  <= 5'd0;
                        r_fault      <= 1'b0;
                        r_fault_code <= 2'd0;
                        r_fault_rail <= 3'd0;
                        r_cnt        <= 32'd0;
                        r_attempt    <= r_attempt + 2'd1;
                    end
`endif
                end
                default: begin
                    r_state <= S_IDLE;
                    r_en    <= 5'd0;
                    r_cnt   <= 32'd0;
                end
            endcase
        end
    end

    assign o_en        = r_en;
    assign o_allGood   = r_all_good;
    assign o_fault     = r_fault;
    assign o_faultRail = r_fault_rail;
    assign o_faultCode = r_fault_code;
    assign o_state     = r_state;

endmodule

// File: tb/tb_power_sequencer.sv
// tb_power_sequencer: directed table, corner-case sequences and randomized
// scenarios checked against a timeline model for power_sequencer.
// Parameters: TIMEOUT_CYCLES=8, STEP_DELAY=2, SETTLE_DELAY=4, RETRY_DELAY=5.
module tb_power_sequencer;

    localparam int BIG = 1 << 30;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic [4:0] pg;
    logic [4:0] en;
    logic       all_good;
    logic       fault;
    logic [2:0] fault_rail;
    logic [1:0] fault_code;
    logic [2:0] state;

    int n_checks = 0;
    int n_fail   = 0;

    power_sequencer #(
        .TIMEOUT_CYCLES(32'd8),
        .STEP_DELAY    (32'd2),
        .SETTLE_DELAY  (32'd4),
        .RETRY_DELAY   (32'd5)
    ) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_enable   (enable),
        .i_pg       (pg),
        .o_en       (en),
        .o_allGood  (all_good),
        .o_fault    (fault),
        .o_faultRail(fault_rail),
        .o_faultCode(fault_code),
        .o_state    (state)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       en_in;
        logic [4:0] pg_in;
        int         steps;
        logic [4:0] en_exp;
        logic       ag_exp;
        logic       flt_exp;
        logic [1:0] code_exp;
        logic [2:0] rail_exp;
        logic [2:0] st_exp;
    } vec_t;

    vec_t vecs[18];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Power-good mirrors the enables except for rails masked off
    task automatic follow(input logic [4:0] mask);
        pg = en & mask;
        tick();
    endtask

    task automatic random_scenario(input int id);
        int d[5];
        int t_en[5];
        int clr[5];
        int fault_edge, f_code, f_rail, run_edge, off_edge, pulse_edge;
        int drop_n, drop_rail, last, mode, hold, pg_edge;
        logic [4:0] e_en;
        logic [4:0] pg_v;
        logic       e_flt;
        fault_edge = BIG; run_edge = BIG; pulse_edge = -1;
        drop_n = -1; drop_rail = 0; f_code = 0; f_rail = 0;
        for (int k = 0; k < 5; k++) begin
            d[k]    = int'($urandom_range(0, 7));
            t_en[k] = BIG;
            clr[k]  = BIG;
        end
        if ($urandom_range(0, 3) == 0) d[$urandom_range(0, 4)] = int'($urandom_range(8, 12));
        // Enable timeline: rail k's power-good, driven d cycles after its enable,
        // is seen one edge later; next enable follows STEP_DELAY edges after that.
        t_en[0] = 1;
        for (int k = 0; k < 5; k++) begin
            if (d[k] >= 8) begin
                fault_edge = t_en[k] + 8;
                f_code = 1;
                f_rail = k;
                break;
            end
            pg_edge = t_en[k] + d[k] + 1;
            if (k < 4) t_en[k + 1] = pg_edge + 2;
            else       run_edge    = pg_edge + 4;
        end
        hold = int'($urandom_range(0, 5));
        mode = int'($urandom_range(0, 1));
        if (fault_edge != BIG) begin
            off_edge = fault_edge + 2;
            last     = fault_edge + 3;
        end else if (mode == 0) begin
            drop_n     = run_edge + hold;
            drop_rail  = int'($urandom_range(0, 4));
            fault_edge = drop_n + 1;
            f_code     = 2;
            f_rail     = drop_rail;
            off_edge   = fault_edge + 2;
            last       = fault_edge + 3;
        end else begin
            off_edge = run_edge + hold;
            for (int k = 0; k < 5; k++) clr[k] = off_edge + 1 + (4 - k) * 3;
            pulse_edge = off_edge + 3;
            last       = clr[0] + 1;
        end
        $display("scenario %0d: d=%0d,%0d,%0d,%0d,%0d fault_code=%0d rail=%0d shutdown=%0d hold=%0d",
                 id, d[0], d[1], d[2], d[3], d[4], f_code, f_rail, (clr[0] != BIG), hold);
        for (int n = 0; n <= last; n++) begin
            for (int k = 0; k < 5; k++) e_en[k] = (n >= t_en[k]) && (n < fault_edge) && (n < clr[k]);
            e_flt = (n >= fault_edge) && (n <= off_edge);
            chk("rnd_en", int'(en), int'(e_en));
            chk("rnd_allgood", int'(all_good),
                int'((n >= run_edge) && (n < fault_edge) && (n <= off_edge)));
            chk("rnd_fault", int'(fault), int'(e_flt));
            chk("rnd_code", int'(fault_code), e_flt ? f_code : 0);
            chk("rnd_rail", int'(fault_rail), e_flt ? f_rail : 0);
            if (n == run_edge) chk("rnd_state_run", int'(state), 4);
            if (n == last)     chk("rnd_state_idle", int'(state), 0);
            enable = (n < off_edge) || (n == pulse_edge);
            for (int k = 0; k < 5; k++)
                pg_v[k] = (d[k] < 8) && (t_en[k] != BIG) && (n >= t_en[k] + d[k]) &&
                          (n < last) && !((k == drop_rail) && (n == drop_n));
            pg = pg_v;
            tick();
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [4:0] seq[5];
        int cnt_rise;
        logic prev;
        rst = 1'b1; enable = 1'b0; pg = 5'd0;
        tick(); tick();
        chk("rst_en", int'(en), 0);
        chk("rst_allgood", int'(all_good), 0);
        chk("rst_fault", int'(fault), 0);
        chk("rst_rail", int'(fault_rail), 0);
        chk("rst_code", int'(fault_code), 0);
        chk("rst_state", int'(state), 0);
        rst = 1'b0;

        // Clean power-up with power-good 3 cycles after each enable, then dropout on rail 1
        vecs[0]  = '{1'b0, 5'h00, 1, 5'h00, 1'b0, 1'b0, 2'd0, 3'd0, 3'd0};
        vecs[1]  = '{1'b1, 5'h00, 1, 5'h01, 1'b0, 1'b0, 2'd0, 3'd0, 3'd1};
        vecs[2]  = '{1'b1, 5'h00, 3, 5'h01, 1'b0, 1'b0, 2'd0, 3'd0, 3'd1};
        vecs[3]  = '{1'b1, 5'h01, 1, 5'h01, 1'b0, 1'b0, 2'd0, 3'd0, 3'd2};
        vecs[4]  = '{1'b1, 5'h01, 2, 5'h03, 1'b0, 1'b0, 2'd0, 3'd0, 3'd1};
        vecs[5]  = '{1'b1, 5'h01, 3, 5'h03, 1'b0, 1'b0, 2'd0, 3'd0, 3'd1};
        vecs[6]  = '{1'b1, 5'h03, 3, 5'h07, 1'b0, 1'b0, 2'd0, 3'd0, 3'd1};
        vecs[7]  = '{1'b1, 5'h03, 3, 5'h07, 1'b0, 1'b0, 2'd0, 3'd0, 3'd1};
        vecs[8]  = '{1'b1, 5'h07, 3, 5'h0F, 1'b0, 1'b0, 2'd0, 3'd0, 3'd1};
        vecs[9]  = '{1'b1, 5'h07, 3, 5'h0F, 1'b0, 1'b0, 2'd0, 3'd0, 3'd1};
        vecs[10] = '{1'b1, 5'h0F, 3, 5'h1F, 1'b0, 1'b0, 2'd0, 3'd0, 3'd1};
        vecs[11] = '{1'b1, 5'h0F, 3, 5'h1F, 1'b0, 1'b0, 2'd0, 3'd0, 3'd1};
        vecs[12] = '{1'b1, 5'h1F, 1, 5'h1F, 1'b0, 1'b0, 2'd0, 3'd0, 3'd3};
        vecs[13] = '{1'b1, 5'h1F, 3, 5'h1F, 1'b0, 1'b0, 2'd0, 3'd0, 3'd3};
        vecs[14] = '{1'b1, 5'h1F, 1, 5'h1F, 1'b1, 1'b0, 2'd0, 3'd0, 3'd4};
        vecs[15] = '{1'b1, 5'h1D, 1, 5'h00, 1'b0, 1'b1, 2'd2, 3'd1, 3'd6};
        vecs[16] = '{1'b1, 5'h1F, 1, 5'h00, 1'b0, 1'b1, 2'd2, 3'd1, 3'd6};
        vecs[17] = '{1'b0, 5'h00, 1, 5'h00, 1'b0, 1'b0, 2'd0, 3'd0, 3'd0};
        for (int i = 0; i < 18; i++) begin
            enable = vecs[i].en_in;
            pg     = vecs[i].pg_in;
            repeat (vecs[i].steps) tick();
            $display("table row %0d: en=%h allGood=%0d fault=%0d state=%0d", i, en, all_good, fault, state);
            chk($sformatf("tbl%0d_en", i), int'(en), int'(vecs[i].en_exp));
            chk($sformatf("tbl%0d_allgood", i), int'(all_good), int'(vecs[i].ag_exp));
            chk($sformatf("tbl%0d_fault", i), int'(fault), int'(vecs[i].flt_exp));
            chk($sformatf("tbl%0d_code", i), int'(fault_code), int'(vecs[i].code_exp));
            chk($sformatf("tbl%0d_rail", i), int'(fault_rail), int'(vecs[i].rail_exp));
            chk($sformatf("tbl%0d_state", i), int'(state), int'(vecs[i].st_exp));
        end

        // Timeout on rail 2: fault exactly 8 edges after its enable rises
        enable = 1'b1;
        for (int c = 0; c < 200 && !en[2]; c++) follow(5'h1B);
        chk("to_en2_up", int'(en[2]), 1);
        for (int c = 1; c < 8; c++) follow(5'h1B);
        chk("to_before_en", int'(en), 7);
        chk("to_before_fault", int'(fault), 0);
        follow(5'h1B);
        chk("to_en", int'(en), 0);
        chk("to_fault", int'(fault), 1);
        chk("to_code", int'(fault_code), 1);
        chk("to_rail", int'(fault_rail), 2);
        enable = 1'b0; pg = 5'd0;
        tick();
        chk("to_clr_state", int'(state), 0);
        chk("to_clr_fault", int'(fault), 0);
        chk("to_clr_code", int'(fault_code), 0);
        $display("timeout sequence done");

        // Orderly shutdown from RUN with an ignored enable pulse
        enable = 1'b1;
        for (int c = 0; c < 300 && !all_good; c++) follow(5'h1F);
        chk("sd_run", int'(all_good), 1);
        enable = 1'b0;
        tick();
        chk("sd_first_en", int'(en), 5'h0F);
        chk("sd_first_ag", int'(all_good), 0);
        chk("sd_first_state", int'(state), 5);
        seq[0] = 5'h0F; seq[1] = 5'h07; seq[2] = 5'h03; seq[3] = 5'h01; seq[4] = 5'h00;
        for (int j = 1; j < 5; j++) begin
            for (int s = 0; s < 3; s++) begin
                enable = (j == 1) && (s == 0);
                tick();
                chk($sformatf("sd_step%0d_%0d", j, s), int'(en), (s < 2) ? int'(seq[j - 1]) : int'(seq[j]));
            end
        end
        chk("sd_idle", int'(state), 0);
        pg = 5'd0;
        tick();
        chk("sd_idle_hold", int'(state), 0);
        $display("shutdown sequence done");

        // Abort during the gap after rail 1
        enable = 1'b1;
        for (int c = 0; c < 100 && !(state == 3'd2 && en == 5'h03); c++) follow(5'h1F);
        chk("ab_gap", int'(state), 2);
        enable = 1'b0;
        tick();
        chk("ab_en1", int'(en), 1);
        chk("ab_state", int'(state), 5);
        tick(); tick();
        chk("ab_hold", int'(en), 1);
        tick();
        chk("ab_en0", int'(en), 0);
        chk("ab_idle", int'(state), 0);
        pg = 5'd0;
        $display("abort sequence done");

        // Reset while settling
        enable = 1'b1;
        for (int c = 0; c < 200 && state != 3'd3; c++) follow(5'h1F);
        chk("rs_settle", int'(state), 3);
        rst = 1'b1;
        tick();
        chk("rs_en", int'(en), 0);
        chk("rs_ag", int'(all_good), 0);
        chk("rs_fault", int'(fault), 0);
        chk("rs_state", int'(state), 0);
        rst = 1'b0; enable = 1'b0; pg = 5'd0;
        tick();
        chk("rs_idle", int'(state), 0);
        $display("reset sequence done");

`ifdef PSEQ_AUTO_RETRY_EN
        // Rail 0 stuck low: initial attempt plus three retries, then latched
        enable = 1'b1; pg = 5'd0;
        cnt_rise = 0; prev = en[0];
        for (int c = 0; c < 120; c++) begin
            tick();
            if (en[0] && !prev) cnt_rise++;
            prev = en[0];
        end
        chk("rt_attempts", cnt_rise, 4);
        chk("rt_fault", int'(fault), 1);
        chk("rt_en", int'(en), 0);
        enable = 1'b0;
        tick();
        chk("rt_idle", int'(state), 0);
        $display("retry sequence done");
`else
        cnt_rise = 0; prev = 1'b0;
        if (prev) cnt_rise++;
`endif

        for (int i = 0; i < 30; i++) random_scenario(i);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
